// File: rtl/handshake_arbiter_if.sv
// Signal bundle between the requesters, the arbiter and the pipeline input port.
// The arbiter connects through the master modport; sources and pipeline use slave.
interface handshake_arbiter_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] data;
    logic [N-1:0]       ack;
    logic               pipe_req;
    logic [WIDTH-1:0]   pipe_data;
    logic               pipe_ack;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic [15:0]        xfer_count;

    modport master (
        input  req, data, pipe_ack,
        output ack, pipe_req, pipe_data, grant_id, busy, xfer_count
    );

    modport slave (
        output req, data, pipe_ack,
        input  ack, pipe_req, pipe_data, grant_id, busy, xfer_count
    );
endinterface

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter relaying N four-phase requesters into one four-phase
// bundled-data pipeline input; all handshake inputs are synchronized first.
module handshake_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    handshake_arbiter_if.master bus
);
    localparam int unsigned IW = $clog2(N);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [SYNC_STAGES-1:0][N-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0]        pack_sync_q;
    logic [N-1:0]                  req_s;
    logic                          pack_s;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic             pipe_req_q, pipe_req_d;
    logic [WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic [N-1:0]     ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [15:0]      xfer_q, xfer_d;

    logic             found;
    logic [IW-1:0]    winner;
    int unsigned      idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync_q  <= '0;
            pack_sync_q <= '0;
        end else begin
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], bus.req};
            pack_sync_q <= {pack_sync_q[SYNC_STAGES-2:0], bus.pipe_ack};
        end
    end

    assign req_s  = req_sync_q[SYNC_STAGES-1];
    assign pack_s = pack_sync_q[SYNC_STAGES-1];

    // First set request scanning upward from ptr, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!found && req_s[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        pipe_req_d  = pipe_req_q;
        pipe_data_d = pipe_data_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        xfer_d      = xfer_q;
        case (state_q)
            IDLE: begin
                if (found && !pack_s) begin
                    state_d     = SEND;
                    grant_d     = winner;
                    pipe_data_d = bus.data[32'(winner)*WIDTH +: WIDTH];
                    pipe_req_d  = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            SEND: begin
                if (pack_s) begin
                    state_d        = RELEASE;
                    pipe_req_d     = 1'b0;
                    ack_d          = '0;
                    ack_d[grant_q] = 1'b1;
                end
            end
            RELEASE: begin
                if (!req_s[grant_q] && !pack_s) begin
                    state_d = IDLE;
                    ack_d   = '0;
                    ptr_d   = (32'(grant_q) == N - 1) ? '0 : grant_q + IW'(1);
                    xfer_d  = xfer_q + 16'd1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                pipe_req_d = 1'b0;
                ack_d      = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            pipe_req_q  <= 1'b0;
            pipe_data_q <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            xfer_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            pipe_req_q  <= pipe_req_d;
            pipe_data_q <= pipe_data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            xfer_q      <= xfer_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.pipe_req   = pipe_req_q;
    assign bus.pipe_data  = pipe_data_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = busy_q;
    assign bus.xfer_count = xfer_q;
endmodule
